div_seq: RTL and testbench
==========================

// Module: div_seq
// PURPOSE
//  Sequential signed 32-bit divider: the HI/LO counterpart of the Booth multiplier.
//  Computes a / b with MIPS DIV semantics. The quotient goes to lo and the remainder to hi.
//  Sits beside the multiplier in the datapath; the control unit starts it with comecodiv.
//  It waits on pronto before reading hi/lo.
// PARAMETERS
//  WIDTH  32  operand/result width; iteration count equals WIDTH
// PORTS
//  clock     in   1      system clock, all state on posedge
//  reset     in   1      asynchronous, active-high; clears all state and outputs
//  comecodiv in   1      start request, sampled only in ESPERA
//  a         in   WIDTH  dividend (two's complement), captured in INICIAL
//  b         in   WIDTH  divisor (two's complement), captured in INICIAL
//  hi        out  WIDTH  remainder, registered
//  lo        out  WIDTH  quotient, registered
//  pronto    out  1      one-cycle pulse: result or div_zero valid
//  div_zero  out  1      high with pronto when b==0; held until next start
// BEHAVIOUR
//  Reset (async, any state): state=ESPERA; hi, lo, pronto, div_zero, counter, working regs = 0.
//  FSM ESPERA -> INICIAL -> REPETICAO(xWIDTH) -> FIM -> ESPERA.
//   ESPERA: on comecodiv=1, go to INICIAL. Clear div_zero. Otherwise idle; pronto=0.
//   INICIAL: latch sign_q=a[W-1]^b[W-1] and sign_r=a[W-1].
//    Load rem=0 (W+1 bits), quo=|a|, dvs=|b|, counter=0.
//    |x| is the unsigned W-bit negate, so |0x80000000| = 0x80000000.
//    If b==0: go to FIM with div_zero set; skip REPETICAO.
//   REPETICAO: restoring step each cycle:
//    {rem,quo} <<= 1; trial = rem - dvs.
//    If trial >= 0: rem = trial, quo[0] = 1; else quo[0] = 0.
//    counter++. Leave after WIDTH steps (counter==WIDTH-1 at that edge).
//   FIM: if !div_zero: lo = sign_q ? -quo : quo; hi = sign_r ? -rem[W-1:0] : rem[W-1:0].
//    pronto=1 for this cycle only. Next state ESPERA.
//  Latency: comecodiv sampled at edge N -> INICIAL at N+1 -> steps N+2..N+W+1.
//   FIM at N+W+2: hi/lo updated and pronto high after that edge (W+2 cycles). Div-by-zero: pronto after N+2.
//  Semantics: quotient truncates toward zero; remainder carries the dividend's sign (or is 0).
//  Overflow: 0x80000000 / -1 -> lo=0x80000000, hi=0, div_zero=0 (wrap, no trap).
//  Divide by zero: hi/lo keep their previous values; div_zero=1 and pronto=1 together.
//  comecodiv while busy (not ESPERA): ignored, no restart, no queueing.
//  a/b may change after INICIAL without affecting the result.
//  Reset mid-operation: aborts immediately; no pronto pulse; outputs read 0.
//  hi/lo change only in FIM or reset; they hold between operations.
// STRUCTURE
//  Shared package/header div_mult_defs: state encodings ESPERA=0, INICIAL=1, REPETICAO=2, FIM=3 (2 bits).
//   Also the WIDTH default; the multiplier reuses it.
//  Single module, no sub-module: one FSM block, one W+1-bit subtractor, counter $clog2(WIDTH)+1 bits.
//  Sign fix-up (negates) in FIM only; no combinational path from a/b to outputs.
// TESTING
//  1. a=100, b=7, pulse comecodiv -> after 34 cycles pronto=1, lo=14, hi=2, div_zero=0.
//  2. a=-100 (0xFFFFFF9C), b=7 -> lo=0xFFFFFFF2 (-14), hi=0xFFFFFFFE (-2).
//     a=100, b=-7 -> lo=-14, hi=2.
//  3. a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0. Then a=7, b=100 -> lo=0, hi=7.
//  4. After test 1, a=55, b=0 -> pronto and div_zero high 2 cycles after start.
//     hi=2 and lo=14 remain unchanged.
//  5. Start a=100, b=7; re-pulse comecodiv at cycle 10 with a=9, b=3 -> single pronto at cycle 34.
//     Result 14/2; second request dropped.
//  6. Start, assert reset asynchronously mid-cycle at step 15 -> hi=lo=0 at once, state ESPERA, no pronto.
//     Fresh start then completes correctly.

Source files
------------

// File: rtl/div_seq_pkg.sv
// Shared divider/multiplier definitions: FSM state encodings and default width.
package div_mult_defs;

  // Operand/result width shared by the sequential divider and the Booth multiplier.
  localparam int DEF_WIDTH = 32;

  typedef enum logic [1:0] {
    ESPERA    = 2'd0,
    INICIAL   = 2'd1,
    REPETICAO = 2'd2,
    FIM       = 2'd3
  } state_e;

endpackage : div_mult_defs

// File: rtl/div_seq_if.sv
// Handshake and data bundle between the control unit and the divider.
interface div_seq_if
  import div_mult_defs::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             comecodiv;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             pronto;
  logic             div_zero;

  modport master (
    output comecodiv, a, b,
    input  hi, lo, pronto, div_zero
  );

  modport slave (
    input  comecodiv, a, b,
    output hi, lo, pronto, div_zero
  );

endinterface : div_seq_if

// File: rtl/div_seq.sv
// Sequential signed restoring divider with MIPS DIV semantics: quotient to lo,
// remainder to hi, one quotient bit per cycle, sign fix-up in the final state.
module div_seq
  import div_mult_defs::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic      clock,
  input  logic      reset,
  div_seq_if.slave  bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_e           state_q, state_d;
  logic             sign_quo_q, sign_quo_d;
  logic             sign_rem_q, sign_rem_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             pronto_q, pronto_d;
  logic             div_zero_q, div_zero_d;

  // Magnitudes are plain W-bit negates, so the most negative value maps to itself
  // and is then treated as the unsigned 2^(W-1).
  logic [WIDTH-1:0] abs_a, abs_b;
  // The partial remainder stays below the divisor, so after the shift it needs
  // W+1 bits; the top bit of the difference is the borrow.
  logic [WIDTH:0]   shifted, trial;
  logic             trial_ok;

  assign abs_a    = bus.a[WIDTH-1] ? ('0 - bus.a) : bus.a;
  assign abs_b    = bus.b[WIDTH-1] ? ('0 - bus.b) : bus.b;
  assign shifted  = {rem_q, quo_q[WIDTH-1]};
  assign trial    = shifted - {1'b0, dvs_q};
  assign trial_ok = ~trial[WIDTH];

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (reset) state_q <= ESPERA;
    else       state_q <= state_d;
  end

  // Next-state logic: start only from ESPERA, skip iterations on a zero divisor.
  always_comb begin
    // NOTE: defaulting every comb output first means no path leaves it unassigned,
    // which is what prevents latch inference.
    state_d = state_q;
    unique case (state_q)
      ESPERA:    if (bus.comecodiv) state_d = INICIAL;
      INICIAL:   state_d = (bus.b == '0) ? FIM : REPETICAO;
      REPETICAO: if (cnt_q == CW'(WIDTH - 1)) state_d = FIM;
      FIM:       state_d = ESPERA;
      default:   state_d = ESPERA;
    endcase
  end

  // Datapath and output logic: operand load, restoring step, sign fix-up.
  always_comb begin
    sign_quo_d = sign_quo_q;
    sign_rem_d = sign_rem_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvs_d      = dvs_q;
    cnt_d      = cnt_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    pronto_d   = 1'b0;
    div_zero_d = div_zero_q;
    unique case (state_q)
      ESPERA: begin
        if (bus.comecodiv) div_zero_d = 1'b0;
      end
      INICIAL: begin
        sign_quo_d = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
        sign_rem_d = bus.a[WIDTH-1];
        rem_d      = '0;
        quo_d      = abs_a;
        dvs_d      = abs_b;
        cnt_d      = '0;
        div_zero_d = (bus.b == '0);
      end
      REPETICAO: begin
        rem_d = trial_ok ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], trial_ok};
        cnt_d = cnt_q + 1'b1;
      end
      FIM: begin
        pronto_d = 1'b1;
        // A zero divisor leaves the previous hi/lo visible.
        if (!div_zero_q) begin
          lo_d = sign_quo_q ? ('0 - quo_q) : quo_q;
          hi_d = sign_rem_q ? ('0 - rem_q) : rem_q;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; reset clears results and working state alike.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sign_quo_q <= 1'b0;
      sign_rem_q <= 1'b0;
      rem_q      <= '0;
      quo_q      <= '0;
      dvs_q      <= '0;
      cnt_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      pronto_q   <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      sign_quo_q <= sign_quo_d;
      sign_rem_q <= sign_rem_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dvs_q      <= dvs_d;
      cnt_q      <= cnt_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      pronto_q   <= pronto_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.pronto   = pronto_q;
  assign bus.div_zero = div_zero_q;

endmodule : div_seq

// File: tb/tb_div_seq.sv
// Directed self-checking bench for the sequential signed divider.
module tb_div_seq;
  import div_mult_defs::*;

  logic clock;
  logic reset;
  int   n_total = 0;
  int   n_pass  = 0;
  int   n_fail  = 0;

  div_seq_if #(.WIDTH(32)) bus ();

  div_seq #(.WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Pulse comecodiv for one posedge; returns on the negedge after that posedge.
  task automatic start(input logic [31:0] av, input logic [31:0] bv);
    @(negedge clock);
    bus.a         = av;
    bus.b         = bv;
    bus.comecodiv = 1'b1;
    @(negedge clock);
    bus.comecodiv = 1'b0;
  endtask

  // Counts posedges from the start edge until pronto is seen, bounded at 100.
  task automatic wait_pronto(output int cyc);
    cyc = 0;
    while (bus.pronto !== 1'b1 && cyc < 100) begin
      @(negedge clock);
      cyc++;
    end
  endtask

  initial begin
    int cyc;
    int pulses;
    int first;

    reset         = 1'b1;
    bus.comecodiv = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    repeat (2) @(negedge clock);
    check("rst_hi", bus.hi, 32'h0);
    check("rst_lo", bus.lo, 32'h0);
    check("rst_pronto", {31'b0, bus.pronto}, 32'h0);
    check("rst_dz", {31'b0, bus.div_zero}, 32'h0);
    check("rst_state", {30'b0, dut.state_q}, {30'b0, ESPERA});
    reset = 1'b0;

    // 100 / 7
    start(32'd100, 32'd7);
    wait_pronto(cyc);
    check("t1_latency", cyc, 32'd34);
    check("t1_lo", bus.lo, 32'd14);
    check("t1_hi", bus.hi, 32'd2);
    check("t1_dz", {31'b0, bus.div_zero}, 32'h0);
    @(negedge clock);
    check("t1_pulse_end", {31'b0, bus.pronto}, 32'h0);

    // 55 / 0: early pronto, results held
    start(32'd55, 32'd0);
    wait_pronto(cyc);
    check("t4_latency", cyc, 32'd2);
    check("t4_dz", {31'b0, bus.div_zero}, 32'h1);
    check("t4_hi_kept", bus.hi, 32'd2);
    check("t4_lo_kept", bus.lo, 32'd14);
    @(negedge clock);
    check("t4_pulse_end", {31'b0, bus.pronto}, 32'h0);
    check("t4_dz_held", {31'b0, bus.div_zero}, 32'h1);

    // -100 / 7
    start(32'hFFFF_FF9C, 32'd7);
    wait_pronto(cyc);
    check("t2a_latency", cyc, 32'd34);
    check("t2a_lo", bus.lo, 32'hFFFF_FFF2);
    check("t2a_hi", bus.hi, 32'hFFFF_FFFE);
    check("t2a_dz_cleared", {31'b0, bus.div_zero}, 32'h0);

    // 100 / -7
    start(32'd100, 32'hFFFF_FFF9);
    wait_pronto(cyc);
    check("t2b_latency", cyc, 32'd34);
    check("t2b_lo", bus.lo, 32'hFFFF_FFF2);
    check("t2b_hi", bus.hi, 32'd2);

    // Overflow wrap: 0x80000000 / -1
    start(32'h8000_0000, 32'hFFFF_FFFF);
    wait_pronto(cyc);
    check("t3a_latency", cyc, 32'd34);
    check("t3a_lo", bus.lo, 32'h8000_0000);
    check("t3a_hi", bus.hi, 32'h0);
    check("t3a_dz", {31'b0, bus.div_zero}, 32'h0);

    // Dividend smaller than divisor: 7 / 100
    start(32'd7, 32'd100);
    wait_pronto(cyc);
    check("t3b_lo", bus.lo, 32'd0);
    check("t3b_hi", bus.hi, 32'd7);

    // Re-pulse while busy with new operands: must be ignored
    start(32'd100, 32'd7);
    pulses = 0;
    first  = 0;
    for (int c = 1; c <= 60; c++) begin
      if (c == 10) begin
        bus.a         = 32'd9;
        bus.b         = 32'd3;
        bus.comecodiv = 1'b1;
      end
      if (c == 11) bus.comecodiv = 1'b0;
      @(negedge clock);
      if (bus.pronto === 1'b1) begin
        pulses++;
        if (first == 0) first = c;
      end
    end
    check("t5_first_pronto", first, 32'd34);
    check("t5_pulses", pulses, 32'd1);
    check("t5_lo", bus.lo, 32'd14);
    check("t5_hi", bus.hi, 32'd2);

    // Asynchronous reset in the middle of the iterations
    start(32'd200, 32'd9);
    repeat (15) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("t6_hi_zero", bus.hi, 32'h0);
    check("t6_lo_zero", bus.lo, 32'h0);
    check("t6_pronto", {31'b0, bus.pronto}, 32'h0);
    check("t6_state", {30'b0, dut.state_q}, {30'b0, ESPERA});
    repeat (2) @(negedge clock);
    reset  = 1'b0;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (bus.pronto === 1'b1) pulses++;
    end
    check("t6_no_pronto", pulses, 32'd0);

    // Fresh start after the abort: 1000 / -33
    start(32'd1000, 32'hFFFF_FFDF);
    wait_pronto(cyc);
    check("t6_latency", cyc, 32'd34);
    check("t6_lo", bus.lo, 32'hFFFF_FFE2);
    check("t6_hi", bus.hi, 32'd10);
    check("t6_dz", {31'b0, bus.div_zero}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule : tb_div_seq
